// File: rtl/menu_cmd_arbiter.sv
// Menu front end: merges debounced buttons and UART command bytes into one (lr_idx, ud_idx) state.
// Button edges take priority over queued UART bytes. A blocked byte stays at the FIFO head.
module menu_cmd_arbiter #(
    parameter int LR_STATES  = 4,
    parameter int UD_STATES  = 4,
    parameter int LR_W       = 2,
    parameter int UD_W       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit WRAP       = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn_l,
    input  logic                          btn_r,
    input  logic                          btn_u,
    input  logic                          btn_d,
    input  logic                          uart_rvalid,
    input  logic [7:0]                    uart_rdata,
    output logic                          uart_ren,
    output logic [LR_W-1:0]               lr_idx,
    output logic [UD_W-1:0]               ud_idx,
    output logic                          cmd_strobe,
    output logic                          uart_seen,
    output logic                          fifo_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {G_IDLE, G_ACK, G_HOLD1, G_HOLD2} guard_t;

    guard_t            guard_q, guard_d;
    logic              capture;
    logic [3:0]        btn, btn_q, btn_edge;
    logic              any_edge;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty, push, pop;
    logic [7:0]        head, digit;
    logic [LR_W-1:0]   lr_next;
    logic [UD_W-1:0]   ud_next;

    function automatic logic [LR_W-1:0] lr_step(input logic [LR_W-1:0] v, input logic up);
        if (up) begin
            if (int'(v) == LR_STATES - 1) return WRAP ? '0 : v;
            return v + LR_W'(1);
        end
        if (v == '0) return WRAP ? LR_W'(LR_STATES - 1) : v;
        return v - LR_W'(1);
    endfunction

    function automatic logic [UD_W-1:0] ud_step(input logic [UD_W-1:0] v, input logic up);
        if (up) begin
            if (int'(v) == UD_STATES - 1) return WRAP ? '0 : v;
            return v + UD_W'(1);
        end
        if (v == '0) return WRAP ? UD_W'(UD_STATES - 1) : v;
        return v - UD_W'(1);
    endfunction

    // Capture guard: one ack cycle, then two cycles for the UART to drop rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) guard_q <= G_IDLE;
        else        guard_q <= guard_d;
    end

    always_comb begin
        guard_d = guard_q;
        case (guard_q)
            G_IDLE:  if (uart_rvalid) guard_d = G_ACK;
            G_ACK:   guard_d = G_HOLD1;
            G_HOLD1: guard_d = G_HOLD2;
            default: guard_d = G_IDLE;
        endcase
    end

    always_comb begin
        uart_ren = (guard_q == G_ACK);
        capture  = (guard_q == G_IDLE) && uart_rvalid;
    end

    assign btn        = {btn_d, btn_u, btn_r, btn_l};
    assign btn_edge   = btn & ~btn_q;
    assign any_edge   = |btn_edge;
    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign push       = capture && !fifo_full;
    assign pop        = !fifo_empty && !any_edge;
    assign head       = mem[rd_ptr];
    assign digit      = head - 8'h30;

    // Byte storage carries no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            uart_seen  <= 1'b0;
            fifo_ovf   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (capture)              uart_seen <= 1'b1;
            if (capture && fifo_full) fifo_ovf  <= 1'b1;
        end
    end

    always_comb begin
        lr_next = lr_idx;
        ud_next = ud_idx;
        if (any_edge) begin
            if (btn_edge[0] != btn_edge[1]) lr_next = lr_step(lr_idx, btn_edge[1]);
            if (btn_edge[2] != btn_edge[3]) ud_next = ud_step(ud_idx, btn_edge[3]);
        end else if (pop) begin
            case (head)
                "L", "l": lr_next = lr_step(lr_idx, 1'b0);
                "R", "r": lr_next = lr_step(lr_idx, 1'b1);
                "U", "u": ud_next = ud_step(ud_idx, 1'b0);
                "D", "d": ud_next = ud_step(ud_idx, 1'b1);
                default: begin
                    // Digits select a page directly and restart at the first item
                    if (head >= 8'h30 && head <= 8'h39 && int'(digit) < LR_STATES) begin
                        lr_next = LR_W'(digit);
                        ud_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q      <= '0;
            lr_idx     <= '0;
            ud_idx     <= '0;
            cmd_strobe <= 1'b0;
        end else begin
            btn_q      <= btn;
            lr_idx     <= lr_next;
            ud_idx     <= ud_next;
            cmd_strobe <= (lr_next != lr_idx) || (ud_next != ud_idx);
        end
    end
endmodule

// File: tb/tb_menu_cmd_arbiter.sv
// Bench for menu_cmd_arbiter: two configurations share one stimulus stream.
// A queue-based reference model predicts every cycle; a monitor compares independently.
module tb_menu_cmd_arbiter;
    typedef struct packed {
        logic [1:0] lr;
        logic [1:0] ud;
        logic       strobe;
        logic       ren;
        logic       seen;
        logic       ovf;
        logic [2:0] level;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic       uart_rvalid = 1'b0;
    logic [7:0] uart_rdata = 8'h00;
    logic       ren0, ren1, strobe0, strobe1, seen0, seen1, ovf0, ovf1;
    logic [1:0] lr0, lr1, ud0, ud1;
    logic [2:0] lvl0;
    logic [1:0] lvl1;

    always #5 clk = ~clk;

    menu_cmd_arbiter dut0 (
        .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata), .uart_ren(ren0),
        .lr_idx(lr0), .ud_idx(ud0), .cmd_strobe(strobe0), .uart_seen(seen0),
        .fifo_ovf(ovf0), .fifo_level(lvl0)
    );

    menu_cmd_arbiter #(
        .LR_STATES(4), .UD_STATES(3), .LR_W(2), .UD_W(2), .FIFO_DEPTH(2), .WRAP(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata), .uart_ren(ren1),
        .lr_idx(lr1), .ud_idx(ud1), .cmd_strobe(strobe1), .uart_seen(seen1),
        .fifo_ovf(ovf1), .fifo_level(lvl1)
    );

    int         n_tests = 0, n_fail = 0;
    int         n_ren = 0, n_stb0 = 0, n_stb1 = 0;
    bit         rand_mode = 1'b0;
    logic [7:0] tx_q [$];
    exp_t       eq0 [$], eq1 [$];
    exp_t       got0, got1, want0, want1;

    // Reference model state
    int         p_lr [2]    = '{4, 4};
    int         p_ud [2]    = '{4, 3};
    int         p_depth [2] = '{4, 2};
    bit         p_wrap [2]  = '{1'b1, 1'b0};
    int         m_lr [2], m_ud [2], m_guard [2];
    bit         m_seen [2], m_ovf [2];
    logic [7:0] m_q0 [$], m_q1 [$];
    logic [3:0] m_prev = 4'b0;
    logic [7:0] tbl [0:21] = '{"L", "R", "U", "D", "l", "r", "u", "d", "0", "1", "2", "3",
                               "4", "5", "6", "7", "8", "9", 8'h0d, 8'h0a, "x", "?"};

    function automatic int step_up(input int v, input int n, input bit wrap);
        if (v + 1 < n) return v + 1;
        return wrap ? 0 : v;
    endfunction

    function automatic int step_dn(input int v, input int n, input bit wrap);
        if (v > 0) return v - 1;
        return wrap ? n - 1 : v;
    endfunction

    task automatic model_step(input int i, input logic [3:0] edges, input bit in_reset);
        logic [7:0] q [$];
        logic [7:0] c;
        int         lr, ud, old_cnt;
        exp_t       e;
        if (i == 0) q = m_q0; else q = m_q1;
        lr = m_lr[i];
        ud = m_ud[i];
        if (in_reset) begin
            q.delete();
            lr = 0; ud = 0;
            m_guard[i] = 0; m_seen[i] = 1'b0; m_ovf[i] = 1'b0;
        end else begin
            old_cnt = q.size();
            if (edges != 4'b0) begin
                if (edges[0] && !edges[1]) lr = step_dn(lr, p_lr[i], p_wrap[i]);
                if (edges[1] && !edges[0]) lr = step_up(lr, p_lr[i], p_wrap[i]);
                if (edges[2] && !edges[3]) ud = step_dn(ud, p_ud[i], p_wrap[i]);
                if (edges[3] && !edges[2]) ud = step_up(ud, p_ud[i], p_wrap[i]);
            end else if (old_cnt > 0) begin
                c = q.pop_front();
                case (c)
                    "L", "l": lr = step_dn(lr, p_lr[i], p_wrap[i]);
                    "R", "r": lr = step_up(lr, p_lr[i], p_wrap[i]);
                    "U", "u": ud = step_dn(ud, p_ud[i], p_wrap[i]);
                    "D", "d": ud = step_up(ud, p_ud[i], p_wrap[i]);
                    default: begin
                        if (int'(c) >= 48 && int'(c) <= 57 && int'(c) - 48 < p_lr[i]) begin
                            lr = int'(c) - 48;
                            ud = 0;
                        end
                    end
                endcase
            end
            if (m_guard[i] == 0 && uart_rvalid) begin
                m_seen[i] = 1'b1;
                if (old_cnt == p_depth[i]) m_ovf[i] = 1'b1;
                else q.push_back(uart_rdata);
                m_guard[i] = 3;
            end else if (m_guard[i] > 0) begin
                m_guard[i] = m_guard[i] - 1;
            end
        end
        e.lr     = 2'(lr);
        e.ud     = 2'(ud);
        e.strobe = !in_reset && (lr != m_lr[i] || ud != m_ud[i]);
        e.ren    = (m_guard[i] == 3);
        e.seen   = m_seen[i];
        e.ovf    = m_ovf[i];
        e.level  = 3'(q.size());
        m_lr[i]  = lr;
        m_ud[i]  = ud;
        if (i == 0) begin m_q0 = q; eq0.push_back(e); end
        else        begin m_q1 = q; eq1.push_back(e); end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic report(input string name, input exp_t g, input exp_t w);
        $display("FAIL %s @%0t: got lr=%0d ud=%0d stb=%0b ren=%0b seen=%0b ovf=%0b lvl=%0d; expected lr=%0d ud=%0d stb=%0b ren=%0b seen=%0b ovf=%0b lvl=%0d",
                 name, $time, g.lr, g.ud, g.strobe, g.ren, g.seen, g.ovf, g.level,
                 w.lr, w.ud, w.strobe, w.ren, w.seen, w.ovf, w.level);
    endtask

    // Monitor: compares each DUT against the oldest outstanding prediction
    always @(posedge clk) begin
        #1;
        got0 = {lr0, ud0, strobe0, ren0, seen0, ovf0, lvl0};
        got1 = {lr1, ud1, strobe1, ren1, seen1, ovf1, 1'b0, lvl1};
        if (eq0.size() > 0) begin
            want0 = eq0.pop_front();
            n_tests++;
            if (got0 !== want0) begin n_fail++; report("dut0_cycle", got0, want0); end
        end
        if (eq1.size() > 0) begin
            want1 = eq1.pop_front();
            n_tests++;
            if (got1 !== want1) begin n_fail++; report("dut1_cycle", got1, want1); end
        end
    end

    // One clock of stimulus: UART sender honouring ren, model prediction, advance to negedge
    task automatic cycle();
        logic [3:0] b, edges;
        n_ren  += int'(ren0);
        n_stb0 += int'(strobe0);
        n_stb1 += int'(strobe1);
        if (uart_rvalid && ren0) begin
            uart_rvalid = 1'b0;
        end else if (!uart_rvalid && tx_q.size() > 0 && (!rand_mode || $urandom_range(1, 0) == 1)) begin
            uart_rdata  = tx_q.pop_front();
            uart_rvalid = 1'b1;
        end
        b     = {btn_d, btn_u, btn_r, btn_l};
        edges = rst_n ? (b & ~m_prev) : 4'b0;
        model_step(0, edges, !rst_n);
        model_step(1, edges, !rst_n);
        m_prev = rst_n ? b : 4'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_rvalid = 1'b0;
        tx_q.delete();
        {btn_d, btn_u, btn_r, btn_l} = 4'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic run_tx(input string name, input bit toggle);
        int n;
        n = 0;
        while ((tx_q.size() > 0 || uart_rvalid) && n < 80) begin
            if (toggle) begin
                btn_l = (n % 2 == 0);
                btn_r = (n % 2 == 1);
            end
            cycle();
            n++;
        end
        check({name, "_done"}, int'(tx_q.size() == 0 && !uart_rvalid), 1);
    endtask

    initial begin
        // Reset state and a held button acting once
        do_reset();
        check("rst_lr", lr0, 0);
        check("rst_ud", ud0, 0);
        check("rst_seen", seen0, 0);
        check("rst_level", lvl0, 0);
        check("rst_ren", ren0, 0);
        n_stb0 = 0;
        btn_r = 1'b1;
        repeat (10) cycle();
        check("held_btn_lr", lr0, 1);
        check("held_btn_strobes", n_stb0, 1);
        btn_r = 1'b0;
        cycle();

        // Back-to-back UART commands
        do_reset();
        n_ren = 0;
        tx_q.push_back("R"); tx_q.push_back("R"); tx_q.push_back("D");
        run_tx("uart3", 1'b0);
        repeat (4) cycle();
        check("uart3_lr", lr0, 2);
        check("uart3_ud", ud0, 1);
        check("uart3_ren_pulses", n_ren, 3);
        check("uart3_seen", seen0, 1);

        // Wrap versus saturate at the top page
        tx_q.push_back("R");
        run_tx("to3", 1'b0);
        repeat (4) cycle();
        check("to3_lr0", lr0, 3);
        check("to3_lr1", lr1, 3);
        n_stb0 = 0; n_stb1 = 0;
        tx_q.push_back("R");
        run_tx("wrap", 1'b0);
        repeat (4) cycle();
        check("wrap_lr0", lr0, 0);
        check("sat_lr1", lr1, 3);
        check("wrap_strobes0", n_stb0, 1);
        check("sat_strobes1", n_stb1, 0);

        // Button edge on the cycle the queued byte would pop
        tx_q.push_back("L");
        cycle();
        btn_u = 1'b1;
        cycle();
        check("prio_ud0", ud0, 0);
        check("prio_lr0_held", lr0, 0);
        check("prio_level0", lvl0, 1);
        btn_u = 1'b0;
        cycle();
        check("prio_lr0_after", lr0, 3);
        check("prio_level0_after", lvl0, 0);
        repeat (4) cycle();

        // Overflow with pops blocked by continuous button edges
        tx_q.push_back("1"); tx_q.push_back("D"); tx_q.push_back("x");
        tx_q.push_back("U"); tx_q.push_back("R"); tx_q.push_back("R");
        run_tx("ovf", 1'b1);
        check("ovf_level0", lvl0, 4);
        check("ovf_flag0", ovf0, 1);
        check("ovf_level1", lvl1, 2);
        check("ovf_flag1", ovf1, 1);
        btn_l = 1'b0; btn_r = 1'b0;
        repeat (8) cycle();
        check("drain_level0", lvl0, 0);

        // Digit selection, then reset with bytes queued
        tx_q.push_back("7"); tx_q.push_back("2");
        run_tx("digit", 1'b0);
        repeat (4) cycle();
        check("digit_lr0", lr0, 2);
        check("digit_ud0", ud0, 0);
        check("digit_lr1", lr1, 2);
        tx_q.push_back("U"); tx_q.push_back("D");
        run_tx("queued", 1'b1);
        check("queued_level0", lvl0, 2);
        rst_n = 1'b0;
        uart_rvalid = 1'b0;
        btn_l = 1'b0; btn_r = 1'b0;
        cycle();
        check("midrst_level0", lvl0, 0);
        check("midrst_lr0", lr0, 0);
        check("midrst_ovf0", ovf0, 0);
        check("midrst_seen0", seen0, 0);
        rst_n = 1'b1;
        cycle();

        // Randomized traffic
        rand_mode = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7, 0) == 0) btn_l = ~btn_l;
            if ($urandom_range(7, 0) == 0) btn_r = ~btn_r;
            if ($urandom_range(7, 0) == 0) btn_u = ~btn_u;
            if ($urandom_range(7, 0) == 0) btn_d = ~btn_d;
            if ($urandom_range(399, 0) == 0) begin
                rst_n = 1'b0;
                uart_rvalid = 1'b0;
                tx_q.delete();
            end else begin
                rst_n = 1'b1;
                if (tx_q.size() == 0) tx_q.push_back(tbl[$urandom_range(21, 0)]);
            end
            cycle();
        end
        rst_n = 1'b1;
        cycle();
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
